rtdf_feed_supervisor: RTL and testbench

- Sequencing controller for the real-time data feed path: DM9000A controller, rtdf packet processor and sample generator.
- Decides when samples may flow. It holds the sample generator off until the packet buffer is prefilled and re-halts it on underrun.
- Gates the packet processor input while the link is down.
- Contains the path watchdog: if packet arrival stalls, it pulses a reset into the packet processor/RX FIFO.
- Runs on the enet-side clock; all outputs are registered.

---
 rtl/rtdf_feed_supervisor_if.sv | 39 +++
 rtl/rtdf_feed_supervisor.sv | 180 ++++++++++++++++++
 tb/tb_rtdf_feed_supervisor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rtdf_feed_supervisor_if.sv
// Control/status bundle between the feed supervisor and the rtdf data path.
// master: supervisor side (samples path status, drives halts/reset/status).
// slave : data-path side (drives enable/link/buffer status, observes controls).
//   enable, link_status          : feed enable and DM9000A link up
//   words_available, packet_count: packet processor buffer level / rx counter
//   feed_halt, packet_halt       : halts to sample generator / packet processor
//   path_reset                   : reset pulse to packet processor / RX FIFO
//   streaming, state             : status
//   underrun_count, watchdog_count: saturating event counters
interface rtdf_feed_supervisor_if;
  localparam int unsigned WORDS_W  = 9;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned UNDER_W  = 16;
  localparam int unsigned WDOG_W   = 8;

  logic               enable;
  logic               link_status;
  logic [WORDS_W-1:0] words_available;
  logic [WORDS_W-1:0] packet_count;
  logic               feed_halt;
  logic               packet_halt;
  logic               path_reset;
  logic               streaming;
  logic [STATE_W-1:0] state;
  logic [UNDER_W-1:0] underrun_count;
  logic [WDOG_W-1:0]  watchdog_count;

  modport master (
    input  enable, link_status, words_available, packet_count,
    output feed_halt, packet_halt, path_reset, streaming, state,
           underrun_count, watchdog_count
  );

  modport slave (
    output enable, link_status, words_available, packet_count,
    input  feed_halt, packet_halt, path_reset, streaming, state,
           underrun_count, watchdog_count
  );
endinterface

// File: rtl/rtdf_feed_supervisor.sv
// Sequencing controller for the real-time data feed path. Holds the sample
// generator off until the packet buffer is prefilled, re-halts on underrun,
// gates the packet processor while the link is down and runs a stall
// watchdog that pulses path_reset into the packet processor / RX FIFO.
// All outputs are registered from the next-state decode.
// Ports:
//   clk     : supervisor clock (enet domain)
//   reset_n : asynchronous active-low reset
//   bus     : rtdf_feed_supervisor_if.master (status in, halts/status out)
// Build option:
//   RTDF_SUP_AUTORESTART_EN defined   -> RECOVER completion goes to WAIT_LINK
//   RTDF_SUP_AUTORESTART_EN undefined -> RECOVER completion parks in FAULT
module rtdf_feed_supervisor #(
  parameter int unsigned PREFILL_WORDS = 128,
  parameter int unsigned STALL_LIMIT   = 2500000,
  parameter int unsigned STALL_W       = 22,
  parameter int unsigned RESET_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  rtdf_feed_supervisor_if.master bus
);

  localparam int unsigned WORDS_W = 9;
  localparam int unsigned HOLD_W  = 8;
  localparam int unsigned UNDER_W = 16;
  localparam int unsigned WDOG_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINK = 3'd1,
    ST_PREFILL   = 3'd2,
    ST_STREAM    = 3'd3,
    ST_STARVED   = 3'd4,
    ST_RECOVER   = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [WORDS_W-1:0]   pkt_prev_q;
  logic [UNDER_W-1:0]   underrun_q, underrun_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic                 feed_halt_q, feed_halt_d;
  logic                 packet_halt_q, packet_halt_d;
  logic                 path_reset_q, path_reset_d;
  logic                 streaming_q, streaming_d;

  logic in_wd, next_in_wd, pkt_changed, wd_trip, threshold_met;
  logic trip_taken, underrun_taken;

  // Watchdog-supervised states and trip detection.
  assign in_wd         = (state_q == ST_PREFILL) || (state_q == ST_STREAM) ||
                         (state_q == ST_STARVED);
  assign next_in_wd    = (state_d == ST_PREFILL) || (state_d == ST_STREAM) ||
                         (state_d == ST_STARVED);
  assign pkt_changed   = (bus.packet_count != pkt_prev_q);
  assign wd_trip       = in_wd && !pkt_changed &&
                         (stall_q == STALL_W'(STALL_LIMIT - 1));
  assign threshold_met = (bus.words_available >= WORDS_W'(PREFILL_WORDS));

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      stall_q       <= '0;
      hold_q        <= '0;
      pkt_prev_q    <= '0;
      underrun_q    <= '0;
      wdog_q        <= '0;
      feed_halt_q   <= 1'b1;
      packet_halt_q <= 1'b1;
      path_reset_q  <= 1'b0;
      streaming_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_q       <= stall_d;
      hold_q        <= hold_d;
      pkt_prev_q    <= bus.packet_count;
      underrun_q    <= underrun_d;
      wdog_q        <= wdog_d;
      feed_halt_q   <= feed_halt_d;
      packet_halt_q <= packet_halt_d;
      path_reset_q  <= path_reset_d;
      streaming_q   <= streaming_d;
    end
  end

  // Next-state decode: disable > link loss > watchdog > normal sequencing.
  always_comb begin
    state_d        = state_q;
    trip_taken     = 1'b0;
    underrun_taken = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else if (in_wd && !bus.link_status) begin
      state_d = ST_RECOVER;
    end else if (wd_trip) begin
      state_d    = ST_RECOVER;
      trip_taken = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_LINK;
        ST_WAIT_LINK: if (bus.link_status) state_d = ST_PREFILL;
        ST_PREFILL:   if (threshold_met) state_d = ST_STREAM;
        ST_STREAM: begin
          if (bus.words_available == '0) begin
            state_d        = ST_STARVED;
            underrun_taken = 1'b1;
          end
        end
        ST_STARVED:   if (threshold_met) state_d = ST_STREAM;
        ST_RECOVER: begin
          if (hold_q == '0) begin
`ifdef RTDF_SUP_AUTORESTART_EN
            state_d = ST_WAIT_LINK;
`else
            state_d = ST_FAULT;
`endif
          end
        end
        ST_FAULT:     state_d = ST_FAULT;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath decode from the next state.
  always_comb begin
    feed_halt_d   = 1'b1;
    packet_halt_d = 1'b1;
    path_reset_d  = 1'b0;
    streaming_d   = 1'b0;
    stall_d       = '0;
    hold_d        = hold_q;
    underrun_d    = underrun_q;
    wdog_d        = wdog_q;

    case (state_d)
      ST_PREFILL, ST_STARVED: packet_halt_d = 1'b0;
      ST_STREAM: begin
        feed_halt_d   = 1'b0;
        packet_halt_d = 1'b0;
        streaming_d   = 1'b1;
      end
      ST_RECOVER: path_reset_d = 1'b1;
      default: ;
    endcase

    // Stall counter restarts on PREFILL entry and outside supervised states.
    if (next_in_wd && !(state_d == ST_PREFILL && state_q != ST_PREFILL) &&
        !pkt_changed) begin
      stall_d = stall_q + STALL_W'(1);
    end

    // Hold counter sizes the path_reset pulse to RESET_CYCLES cycles.
    if (state_d == ST_RECOVER && state_q != ST_RECOVER) begin
      hold_d = HOLD_W'(RESET_CYCLES - 1);
    end else if (state_q == ST_RECOVER && hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    if (underrun_taken && underrun_q != {UNDER_W{1'b1}}) begin
      underrun_d = underrun_q + UNDER_W'(1);
    end
    if (trip_taken && wdog_q != {WDOG_W{1'b1}}) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  assign bus.state          = state_q;
  assign bus.feed_halt      = feed_halt_q;
  assign bus.packet_halt    = packet_halt_q;
  assign bus.path_reset     = path_reset_q;
  assign bus.streaming      = streaming_q;
  assign bus.underrun_count = underrun_q;
  assign bus.watchdog_count = wdog_q;

endmodule

// File: tb/tb_rtdf_feed_supervisor.sv
// Directed bench for rtdf_feed_supervisor (STALL_LIMIT reduced to 100).
module tb_rtdf_feed_supervisor;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  rtdf_feed_supervisor_if bus_if ();

  rtdf_feed_supervisor #(
    .PREFILL_WORDS (128),
    .STALL_LIMIT   (100),
    .STALL_W       (22),
    .RESET_CYCLES  (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        en;
    logic        link;
    logic [8:0]  words;
    logic [8:0]  pkt;
    logic [2:0]  st;
    logic        fh;
    logic        ph;
    logic        pr;
    logic        strm;
    logic [15:0] und;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic link, input logic [8:0] w, input logic [8:0] p);
    bus_if.enable          = en;
    bus_if.link_status     = link;
    bus_if.words_available = w;
    bus_if.packet_count    = p;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 9'd0, 9'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // RECOVER pulse: already seen high on entry, 15 more cycles high, then exit.
  task automatic recover_tail(input string tag);
    for (int i = 0; i < 15; i++) begin
      step();
      check({tag, "_rec_state"}, 32'(bus_if.state), 32'd5);
      check({tag, "_rec_pr"}, 32'(bus_if.path_reset), 32'd1);
    end
    step();
`ifdef RTDF_SUP_AUTORESTART_EN
    check({tag, "_exit_state"}, 32'(bus_if.state), 32'd1);
`else
    check({tag, "_exit_state"}, 32'(bus_if.state), 32'd6);
`endif
    check({tag, "_exit_pr"}, 32'(bus_if.path_reset), 32'd0);
    check({tag, "_exit_fh"}, 32'(bus_if.feed_halt), 32'd1);
    check({tag, "_exit_ph"}, 32'(bus_if.packet_halt), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //            en    link  words    pkt     st    fh    ph    pr    strm  und
    vecs[0]  = '{1'b0, 1'b1, 9'd0,   9'd0,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 9'd0,   9'd1,  3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 9'd0,   9'd2,  3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 9'd0,   9'd3,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 1'b1, 9'd100, 9'd4,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 9'd127, 9'd5,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b1, 1'b1, 9'd128, 9'd6,  3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[7]  = '{1'b1, 1'b1, 9'd130, 9'd7,  3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[8]  = '{1'b1, 1'b1, 9'd0,   9'd8,  3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 1'b1, 9'd127, 9'd9,  3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 1'b1, 9'd128, 9'd10, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b1, 1'b1, 9'd5,   9'd11, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[12] = '{1'b1, 1'b1, 9'd0,   9'd12, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[13] = '{1'b1, 1'b1, 9'd200, 9'd13, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[14] = '{1'b1, 1'b0, 9'd0,   9'd14, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};

    // Reset state.
    do_reset();
    check("rst_state", 32'(bus_if.state), 32'd0);
    check("rst_fh", 32'(bus_if.feed_halt), 32'd1);
    check("rst_ph", 32'(bus_if.packet_halt), 32'd1);
    check("rst_pr", 32'(bus_if.path_reset), 32'd0);
    check("rst_strm", 32'(bus_if.streaming), 32'd0);
    check("rst_und", 32'(bus_if.underrun_count), 32'd0);
    check("rst_wdog", 32'(bus_if.watchdog_count), 32'd0);

    // Sequencing, prefill threshold, underrun, simultaneous starve + link loss.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].en, vecs[i].link, vecs[i].words, vecs[i].pkt);
      step();
      check($sformatf("v%0d_state", i), 32'(bus_if.state), 32'(vecs[i].st));
      check($sformatf("v%0d_fh", i), 32'(bus_if.feed_halt), 32'(vecs[i].fh));
      check($sformatf("v%0d_ph", i), 32'(bus_if.packet_halt), 32'(vecs[i].ph));
      check($sformatf("v%0d_pr", i), 32'(bus_if.path_reset), 32'(vecs[i].pr));
      check($sformatf("v%0d_strm", i), 32'(bus_if.streaming), 32'(vecs[i].strm));
      check($sformatf("v%0d_und", i), 32'(bus_if.underrun_count), 32'(vecs[i].und));
    end
    check("linkloss_wdog", 32'(bus_if.watchdog_count), 32'd0);
    drive(1'b1, 1'b1, 9'd0, 9'd14);
    recover_tail("ll");

    // Watchdog: wrap counts as change, trip beats threshold, exact latency.
    do_reset();
    drive(1'b1, 1'b1, 9'd0, 9'h1FF);
    step();
    check("wd_wait", 32'(bus_if.state), 32'd1);
    step();
    check("wd_prefill", 32'(bus_if.state), 32'd2);
    for (int i = 0; i < 50; i++) begin
      step();
      check("wd_hold1", 32'(bus_if.state), 32'd2);
    end
    bus_if.packet_count = 9'd0;
    step();
    check("wd_wrap", 32'(bus_if.state), 32'd2);
    for (int i = 1; i < 100; i++) begin
      step();
      check("wd_pretrip", 32'(bus_if.state), 32'd2);
    end
    bus_if.words_available = 9'd128;
    step();
    check("wd_trip_state", 32'(bus_if.state), 32'd5);
    check("wd_trip_count", 32'(bus_if.watchdog_count), 32'd1);
    check("wd_trip_pr", 32'(bus_if.path_reset), 32'd1);
    check("wd_trip_fh", 32'(bus_if.feed_halt), 32'd1);
    bus_if.words_available = 9'd0;
    recover_tail("wd");

`ifndef RTDF_SUP_AUTORESTART_EN
    // FAULT holds until enable drops.
    step();
    check("fault_hold", 32'(bus_if.state), 32'd6);
    bus_if.enable = 1'b0;
    step();
    check("fault_idle", 32'(bus_if.state), 32'd0);
    bus_if.enable = 1'b1;
    step();
    check("fault_restart", 32'(bus_if.state), 32'd1);
`endif
    step();
    check("re_prefill", 32'(bus_if.state), 32'd2);
    check("re_ph", 32'(bus_if.packet_halt), 32'd0);
    bus_if.link_status = 1'b0;
    step();
    check("ll2_state", 32'(bus_if.state), 32'd5);
    check("ll2_wdog", 32'(bus_if.watchdog_count), 32'd1);
    repeat (3) step();
    check("mid_rec_pr", 32'(bus_if.path_reset), 32'd1);

    // Asynchronous reset in the middle of RECOVER.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 32'(bus_if.state), 32'd0);
    check("arst_pr", 32'(bus_if.path_reset), 32'd0);
    check("arst_fh", 32'(bus_if.feed_halt), 32'd1);
    check("arst_wdog", 32'(bus_if.watchdog_count), 32'd0);
    check("arst_und", 32'(bus_if.underrun_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
